// File: rtl/dfe_pam4_ntap_if.sv
// Sample, training, coefficient-write and decision bundle for dfe_pam4_ntap.
// master drives samples and coefficient writes; slave is the equalizer.
interface dfe_pam4_ntap_if #(
    parameter int NUM_TAPS          = 4,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int COEFF_WIDTH       = 8
);
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int W  = 2 * SIGNAL_RESOLUTION;

    logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
    logic                                signal_in_valid;
    logic signed [SIGNAL_RESOLUTION-1:0] train_data;
    logic                                train_data_valid;
    logic                                coeff_wr_en;
    logic        [AW-1:0]                coeff_wr_addr;
    logic signed [COEFF_WIDTH-1:0]       coeff_wr_data;
    logic signed [W-1:0]                 signal_out;
    logic        [1:0]                   symbol_out;
    logic signed [W-1:0]                 error_out;
    logic                                signal_out_valid;
    logic                                locked;

    modport master (
        output signal_in, signal_in_valid,
        output train_data, train_data_valid,
        output coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        input  signal_out, symbol_out, error_out,
        input  signal_out_valid, locked
    );

    modport slave (
        input  signal_in, signal_in_valid,
        input  train_data, train_data_valid,
        input  coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        output signal_out, symbol_out, error_out,
        output signal_out_valid, locked
    );
endinterface

// File: rtl/dfe_pam4_ntap.sv
// PAM4 N-tap decision feedback equalizer with slicer and lock detector.
// Define DFE_LMS_ADAPT_EN to enable sign-sign LMS tap adaptation.
module dfe_pam4_ntap #(
    parameter int NUM_TAPS          = 4,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int COEFF_WIDTH       = 8,
    parameter int COEFF_FRAC        = 6,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int LOCK_COUNT        = 16
) (
    input logic            clk,
    input logic            rst,
    dfe_pam4_ntap_if.slave bus
);
    localparam int SR    = SIGNAL_RESOLUTION;
    localparam int W     = 2 * SR;
    localparam int AW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int ACC_W = COEFF_WIDTH + W + 4;
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    localparam logic signed [W-1:0] S_L    = W'(SYMBOL_SEPERATION);
    localparam logic signed [W-1:0] LVL_HI = W'((3 * SYMBOL_SEPERATION) / 2);
    localparam logic signed [W-1:0] LVL_LO = W'(SYMBOL_SEPERATION / 2);
    localparam logic signed [W-1:0] Q_L    = W'(SYMBOL_SEPERATION / 4);

    localparam logic signed [ACC_W-1:0] EST_MAX =
        ACC_W'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] EST_MIN = -EST_MAX - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

    typedef enum logic {ACQ, LOCK} state_t;

    logic signed [W-1:0]           h_q    [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_q [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_d [NUM_TAPS];

    logic signed [ACC_W-1:0] prod [NUM_TAPS];
    logic signed [ACC_W-1:0] fb_sum;
    logic signed [ACC_W-1:0] est_full;
    logic signed [W-1:0]     est_c;
    logic signed [W-1:0]     lvl_c;
    logic        [1:0]       sym_c;
    logic signed [W:0]       err_full;
    logic signed [W-1:0]     err_c;
    logic                    good_c;
    logic signed [W-1:0]     h_in;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Feedback sum over past decisions and saturated equalized estimate.
    always_comb begin
        fb_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod[k] = ACC_W'(coef_q[k]) * ACC_W'(h_q[k]);
            fb_sum  = fb_sum + (prod[k] >>> COEFF_FRAC);
        end
        est_full = ACC_W'(bus.signal_in) - fb_sum;
        if (est_full > EST_MAX) begin
            est_c = {1'b0, {(W-1){1'b1}}};
        end else if (est_full < EST_MIN) begin
            est_c = {1'b1, {(W-1){1'b0}}};
        end else begin
            est_c = est_full[W-1:0];
        end
    end

    // Four-level slicer; ties resolve upward.
    always_comb begin
        lvl_c = -LVL_HI;
        sym_c = 2'b00;
        unique case (1'b1)
            (est_c >= S_L): begin
                lvl_c = LVL_HI;
                sym_c = 2'b11;
            end
            (est_c >= 0 && est_c < S_L): begin
                lvl_c = LVL_LO;
                sym_c = 2'b10;
            end
            (est_c >= -S_L && est_c < 0): begin
                lvl_c = -LVL_LO;
                sym_c = 2'b01;
            end
            default: begin
                lvl_c = -LVL_HI;
                sym_c = 2'b00;
            end
        endcase
    end

    // Slicer error, saturated, and its lock-window test.
    always_comb begin
        err_full = {est_c[W-1], est_c} - {lvl_c[W-1], lvl_c};
        if (err_full[W] != err_full[W-1]) begin
            err_c = err_full[W] ? {1'b1, {(W-1){1'b0}}}
                                : {1'b0, {(W-1){1'b1}}};
        end else begin
            err_c = err_full[W-1:0];
        end
        good_c = (err_c < Q_L) && (err_c > -Q_L);
    end

    // Value entering the history: training level or own decision.
    always_comb begin
        h_in = bus.train_data_valid ? W'(bus.train_data) : lvl_c;
    end

`ifdef DFE_LMS_ADAPT_EN
    localparam logic signed [COEFF_WIDTH-1:0] C_MAX =
        {1'b0, {(COEFF_WIDTH-1){1'b1}}};
    localparam logic signed [COEFF_WIDTH-1:0] C_MIN =
        {1'b1, {(COEFF_WIDTH-1){1'b0}}};

    logic err_pos, err_neg;
    logic up [NUM_TAPS];
    logic dn [NUM_TAPS];

    // Sign-sign LMS step; an external write to a tap wins over it.
    always_comb begin
        err_pos = (err_c > 0);
        err_neg = (err_c < 0);
        for (int k = 0; k < NUM_TAPS; k++) begin
            up[k] = (err_pos && (h_q[k] > 0)) ||
                    (err_neg && (h_q[k] < 0));
            dn[k] = (err_pos && (h_q[k] < 0)) ||
                    (err_neg && (h_q[k] > 0));
            coef_d[k] = coef_q[k];
            if (bus.signal_in_valid) begin
                if (up[k] && coef_q[k] != C_MAX) begin
                    coef_d[k] = coef_q[k] + 1'b1;
                end else if (dn[k] && coef_q[k] != C_MIN) begin
                    coef_d[k] = coef_q[k] - 1'b1;
                end
            end
            if (bus.coeff_wr_en && bus.coeff_wr_addr == AW'(k)) begin
                coef_d[k] = bus.coeff_wr_data;
            end
        end
    end
`else
    // Taps change only through the write port.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef_d[k] = coef_q[k];
            if (bus.coeff_wr_en && bus.coeff_wr_addr == AW'(k)) begin
                coef_d[k] = bus.coeff_wr_data;
            end
        end
    end
`endif

    // Coefficient register; new value is seen from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= coef_d[k];
            end
        end
    end

    // Decision history shifts only on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                h_q[k] <= '0;
            end
        end else if (bus.signal_in_valid) begin
            h_q[0] <= h_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                h_q[k] <= h_q[k-1];
            end
        end
    end

    // Output register: one result per valid sample, one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.signal_out       <= '0;
            bus.symbol_out       <= 2'b00;
            bus.error_out        <= '0;
            bus.signal_out_valid <= 1'b0;
        end else if (bus.signal_in_valid) begin
            bus.signal_out       <= lvl_c;
            bus.symbol_out       <= sym_c;
            bus.error_out        <= err_c;
            bus.signal_out_valid <= 1'b1;
        end else begin
            bus.signal_out_valid <= 1'b0;
        end
    end

    // Lock FSM state and good-symbol counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock FSM next state: count clean symbols, drop on any bad one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.signal_in_valid) begin
            if (good_c) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_d == CNT_MAX) begin
                    state_d = LOCK;
                end
            end else begin
                cnt_d   = '0;
                state_d = ACQ;
            end
        end
    end

    assign bus.locked = (state_q == LOCK);
endmodule

// File: tb/tb_dfe_pam4_ntap.sv
// Directed bench for dfe_pam4_ntap (default build, four taps, S=56).
// Expected values are hand-computed from the level/threshold arithmetic.
module tb_dfe_pam4_ntap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    dfe_pam4_ntap_if #(
        .NUM_TAPS(4),
        .SIGNAL_RESOLUTION(8),
        .COEFF_WIDTH(8)
    ) bus ();

    dfe_pam4_ntap #(
        .NUM_TAPS(4),
        .SIGNAL_RESOLUTION(8),
        .COEFF_WIDTH(8),
        .COEFF_FRAC(6),
        .SYMBOL_SEPERATION(56),
        .LOCK_COUNT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input bit v,
                        input int t, input bit tv);
        bus.signal_in        = 8'(x);
        bus.signal_in_valid  = v;
        bus.train_data       = 8'(t);
        bus.train_data_valid = tv;
        @(posedge clk);
        #1;
        bus.signal_in_valid  = 1'b0;
        bus.train_data_valid = 1'b0;
        bus.coeff_wr_en      = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = 2'(addr);
        bus.coeff_wr_data = 8'(data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic out3(input string tag, input int lvl,
                        input int sym, input int err);
        chk({tag, "_vld"}, 32'(bus.signal_out_valid), 1);
        chk({tag, "_out"}, 32'(bus.signal_out), lvl);
        chk({tag, "_sym"}, 32'(bus.symbol_out), sym);
        chk({tag, "_err"}, 32'(bus.error_out), err);
    endtask

    initial begin
        bus.signal_in        = '0;
        bus.signal_in_valid  = 1'b0;
        bus.train_data       = '0;
        bus.train_data_valid = 1'b0;
        bus.coeff_wr_en      = 1'b0;
        bus.coeff_wr_addr    = '0;
        bus.coeff_wr_data    = '0;

        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_out", 32'(bus.signal_out), 0);
        chk("rst_sym", 32'(bus.symbol_out), 0);
        chk("rst_err", 32'(bus.error_out), 0);
        chk("rst_vld", 32'(bus.signal_out_valid), 0);
        chk("rst_lock", 32'(bus.locked), 0);
        rst = 1'b0;

        step(30, 1, 0, 0);
        out3("p30", 28, 2, 2);
        step(-30, 1, 0, 0);
        out3("m30", -28, 1, -2);
        step(90, 1, 0, 0);
        out3("p90", 84, 3, 6);
        step(-90, 1, 0, 0);
        out3("m90", -84, 0, -6);
        step(0, 0, 0, 0);
        chk("gap_vld", 32'(bus.signal_out_valid), 0);

        step(56, 1, 0, 0);
        out3("tie_p56", 84, 3, -28);
        step(0, 1, 0, 0);
        out3("tie_0", 28, 2, -28);
        step(-56, 1, 0, 0);
        out3("tie_m56", -28, 1, -28);

        do_reset();
        wr(0, 32);
        step(0, 0, 0, 0);
        step(84, 1, 0, 0);
        out3("c32_a", 84, 3, 0);
        step(100, 1, 0, 0);
        out3("c32_b", 84, 3, -26);
        step(0, 1, 0, 0);
        out3("c32_c", -28, 1, -14);

        do_reset();
        step(84, 1, 0, 0);
        out3("wr_pre", 84, 3, 0);
        wr(0, 64);
        step(84, 1, 0, 0);
        out3("wr_old", 84, 3, 0);
        step(84, 1, 0, 0);
        out3("wr_new", 28, 2, -28);

        do_reset();
        wr(0, 64);
        step(0, 0, 0, 0);
        step(28, 1, -84, 1);
        out3("trn_a", 28, 2, 0);
        step(0, 1, 0, 0);
        out3("trn_b", 84, 3, 0);

        do_reset();
        for (int i = 1; i <= 15; i++) begin
            step(28, 1, 0, 0);
        end
        chk("lock_15", 32'(bus.locked), 0);
        step(28, 1, 0, 0);
        chk("lock_16", 32'(bus.locked), 1);
        chk("lock_16_vld", 32'(bus.signal_out_valid), 1);
        step(28, 1, 0, 0);
        chk("lock_17", 32'(bus.locked), 1);
        step(48, 1, 0, 0);
        out3("bad", 28, 2, 20);
        chk("unlock", 32'(bus.locked), 0);

        do_reset();
        wr(0, 64);
        step(0, 0, 0, 0);
        step(84, 1, 0, 0);
        out3("mid_pre", 84, 3, 0);
        rst = 1'b1;
        step(84, 1, 0, 0);
        chk("mid_vld", 32'(bus.signal_out_valid), 0);
        chk("mid_out", 32'(bus.signal_out), 0);
        rst = 1'b0;
        wr(0, 64);
        step(0, 0, 0, 0);
        chk("mid_gap", 32'(bus.signal_out_valid), 0);
        step(0, 1, 0, 0);
        out3("mid_post", 28, 2, -28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
